// File: rtl/pin_entry_keypad.sv
//==============================================================================
// Module      : pin_entry_keypad
// Description : Turns a serial keypad stream into a parallel PIN word, with
//               wrong-PIN lockout. Optional feature macro: KEY_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pin_entry_keypad #(
    parameter int DIGITS         = 4,
    parameter int password_width = 16,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      card_in,
    input  logic                      key_valid,
    input  logic [3:0]                key_code,
    input  logic                      wrong_psw,
    input  logic                      psw_en,
    output logic [password_width-1:0] password_input,
    output logic                      psw_valid,
    output logic [2:0]                digit_count,
    output logic                      entry_error,
    output logic                      cancel_req,
    output logic                      locked
);

    localparam int         c_att_w  = $clog2(MAX_ATTEMPTS + 1);
    localparam logic [2:0] c_digits = 3'(DIGITS);
    localparam logic [c_att_w-1:0] c_max_att = c_att_w'(MAX_ATTEMPTS);

    localparam logic [3:0] c_key_clear = 4'hA;
    localparam logic [3:0] c_key_bksp  = 4'hB;
    localparam logic [3:0] c_key_enter = 4'hC;
    localparam logic [3:0] c_key_cancel = 4'hD;

    generate
        if (password_width != DIGITS * 4 || DIGITS < 2 || DIGITS > 7 ||
            MAX_ATTEMPTS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_config
            $error("pin_entry_keypad: inconsistent parameters");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_SUBMIT  = 3'd2,
        ST_DONE    = 3'd3,
        ST_LOCKED  = 3'd4
    } state_t;

    state_t                    r_state,  w_state;
    logic [password_width-1:0] r_pin,    w_pin;
    logic [2:0]                r_cnt,    w_cnt;
    logic [c_att_w-1:0]        r_att,    w_att;
    logic                      r_valid,  w_valid;
    logic                      r_err,    w_err;
    logic                      r_cancel, w_cancel;
    logic                      r_locked, w_locked;

`ifdef KEY_TIMEOUT_EN
    localparam int c_idle_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_idle_w-1:0] c_timeout = c_idle_w'(TIMEOUT_CYCLES);
    logic [c_idle_w-1:0] r_idle, w_idle;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_pin    <= '0;
            r_cnt    <= '0;
            r_att    <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_cancel <= 1'b0;
            r_locked <= 1'b0;
`ifdef KEY_TIMEOUT_EN
            r_idle   <= '0;
`endif
        end else begin
            r_state  <= w_state;
            r_pin    <= w_pin;
            r_cnt    <= w_cnt;
            r_att    <= w_att;
            r_valid  <= w_valid;
            r_err    <= w_err;
            r_cancel <= w_cancel;
            r_locked <= w_locked;
`ifdef KEY_TIMEOUT_EN
            r_idle   <= w_idle;
`endif
        end
    end

    always_comb begin
        w_state  = r_state;
        w_pin    = r_pin;
        w_cnt    = r_cnt;
        w_att    = r_att;
        w_valid  = 1'b0;
        w_err    = 1'b0;
        w_cancel = 1'b0;
        w_locked = r_locked;
`ifdef KEY_TIMEOUT_EN
        w_idle   = '0;
`endif

        if (!card_in) begin
            w_state  = ST_IDLE;
            w_pin    = '0;
            w_cnt    = '0;
            w_att    = '0;
            w_locked = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state = ST_COLLECT;
                end

                ST_COLLECT: begin
                    if (key_valid) begin
                        if (key_code <= 4'h9) begin
                            if (r_cnt < c_digits) begin
                                w_pin = {r_pin[password_width-5:0], key_code};
                                w_cnt = r_cnt + 3'd1;
                            end else begin
                                w_err = 1'b1;
                            end
                        end else if (key_code == c_key_clear) begin
                            w_pin = '0;
                            w_cnt = '0;
                        end else if (key_code == c_key_bksp) begin
                            if (r_cnt != 3'd0) begin
                                w_pin = r_pin >> 4;
                                w_cnt = r_cnt - 3'd1;
                            end
                        end else if (key_code == c_key_enter) begin
                            if (r_cnt == c_digits) begin
                                w_state = ST_SUBMIT;
                                w_valid = 1'b1;
                            end else begin
                                w_err = 1'b1;
                            end
                        end else if (key_code == c_key_cancel) begin
                            // Card ejection is left to the downstream ATM FSM.
                            w_cancel = 1'b1;
                            w_pin    = '0;
                            w_cnt    = '0;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
`ifdef KEY_TIMEOUT_EN
                    else if (r_cnt != 3'd0) begin
                        if (r_idle + 1'b1 == c_timeout) begin
                            w_pin = '0;
                            w_cnt = '0;
                            w_err = 1'b1;
                        end else begin
                            w_idle = r_idle + 1'b1;
                        end
                    end
`endif
                end

                ST_SUBMIT: begin
                    if (wrong_psw) begin
                        if (r_att < c_max_att) begin
                            w_att = r_att + 1'b1;
                        end
                        if (r_att + 1'b1 >= c_max_att) begin
                            w_state  = ST_LOCKED;
                            w_locked = 1'b1;
                        end else begin
                            w_state = ST_COLLECT;
                            w_pin   = '0;
                            w_cnt   = '0;
                        end
                    end else if (psw_en) begin
                        w_state = ST_DONE;
                    end
                end

                ST_DONE: begin
                    w_state = ST_DONE;
                end

                ST_LOCKED: begin
                    w_locked = 1'b1;
                end

                default: begin
                    w_state = ST_IDLE;
                    w_pin   = '0;
                    w_cnt   = '0;
                end
            endcase
        end
    end

    assign password_input = r_pin;
    assign psw_valid      = r_valid;
    assign digit_count    = r_cnt;
    assign entry_error    = r_err;
    assign cancel_req     = r_cancel;
    assign locked         = r_locked;

endmodule

`default_nettype wire
